// File: rtl/blockmem_2p_pkg.sv
// Shared constants and types for the blockmem_2p read-port arbiter.
package blockmem_2p_pkg;

  localparam int C_MAX_NREQ = 4;
  localparam int C_IDWIDTH  = 2;

  typedef struct packed {
    logic                 valid;
    logic [C_IDWIDTH-1:0] id;
  } rd_tag_t;

endpackage

// File: rtl/blockmem_2p_rsp_fifo.sv
// Small synchronous FIFO with register storage for read responses.
module blockmem_2p_rsp_fifo #(
  parameter  int WIDTH = 34,
  parameter  int DEPTH = 3,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/blockmem_2p_rd_arb.sv
// Round-robin read-port arbiter with latency tracking and a
// credit-protected response FIFO for port B of blockmem_2p_wrapper.
module blockmem_2p_rd_arb
  import blockmem_2p_pkg::*;
#(
  parameter  int G_NREQ      = 2,
  parameter  int G_DATAWIDTH = 32,
  parameter  int G_MEMDEPTH  = 1024,
  parameter  int G_ADDRWIDTH = $clog2(G_MEMDEPTH),
  parameter  int G_RDLATENCY = 1,
  localparam int G_FIFODEPTH = G_RDLATENCY + 2
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [G_NREQ-1:0]             req_valid,
  input  logic [G_NREQ*G_ADDRWIDTH-1:0] req_addr,
  output logic [G_NREQ-1:0]             req_ready,
  output logic                          rsp_valid,
  output logic [C_IDWIDTH-1:0]          rsp_id,
  output logic [G_DATAWIDTH-1:0]        rsp_data,
  input  logic                          rsp_ready,
  output logic                          mem_enb,
  output logic [G_ADDRWIDTH-1:0]        mem_addrb,
  input  logic [G_DATAWIDTH-1:0]        mem_doutb
);

  localparam int CW = $clog2(G_FIFODEPTH + 1);
  localparam int FW = G_DATAWIDTH + C_IDWIDTH;

  if (G_NREQ < 2 || G_NREQ > C_MAX_NREQ) begin : g_bad_nreq
    $error("G_NREQ out of range");
  end
  if (G_RDLATENCY < 1 || G_RDLATENCY > 2) begin : g_bad_lat
    $error("G_RDLATENCY must be 1 or 2");
  end

  logic [C_IDWIDTH-1:0] last;
  logic [C_IDWIDTH-1:0] gnt_id;
  logic                 found;
  logic [CW-1:0]        credits;
  logic                 can_issue;
  logic                 issue;
  logic                 pop;
  logic                 push;
  rd_tag_t              pipe [G_RDLATENCY];
  logic [FW-1:0]        fifo_dout;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CW-1:0]        fifo_count;

  // A pop only frees its credit from the next cycle on.
  assign can_issue = resetn && (credits < CW'(G_FIFODEPTH));

  // Two passes: above `last` first, then wrap to 0..last.
  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    for (int i = 0; i < G_NREQ; i++) begin
      if (!found && req_valid[i] && i > int'(last)) begin
        found  = 1'b1;
        gnt_id = C_IDWIDTH'(i);
      end
    end
    for (int i = 0; i < G_NREQ; i++) begin
      if (!found && req_valid[i] && i <= int'(last)) begin
        found  = 1'b1;
        gnt_id = C_IDWIDTH'(i);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < G_NREQ; i++) begin
      req_ready[i] = can_issue && found
                     && (gnt_id == C_IDWIDTH'(i));
    end
  end

  assign issue   = |req_ready;
  assign mem_enb = issue;

  always_comb begin
    mem_addrb = req_addr[G_ADDRWIDTH-1:0];
    for (int i = 0; i < G_NREQ; i++) begin
      if (issue && gnt_id == C_IDWIDTH'(i)) begin
        mem_addrb = req_addr[i*G_ADDRWIDTH +: G_ADDRWIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      last <= C_IDWIDTH'(G_NREQ - 1);
    end else if (issue) begin
      last <= gnt_id;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int s = 0; s < G_RDLATENCY; s++) pipe[s] <= '0;
    end else begin
      pipe[0] <= '{valid: issue, id: gnt_id};
      for (int s = 1; s < G_RDLATENCY; s++) pipe[s] <= pipe[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      credits <= '0;
    end else begin
      credits <= credits + CW'(issue) - CW'(pop);
    end
  end

  assign push      = pipe[G_RDLATENCY-1].valid;
  assign rsp_valid = !fifo_empty;
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_id    = fifo_dout[G_DATAWIDTH +: C_IDWIDTH];
  assign rsp_data  = fifo_dout[G_DATAWIDTH-1:0];

  blockmem_2p_rsp_fifo #(
    .WIDTH (FW),
    .DEPTH (G_FIFODEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .din    ({pipe[G_RDLATENCY-1].id, mem_doutb}),
    .pop    (pop),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (resetn) begin
      assert (!(push && fifo_full));
      assert (credits <= CW'(G_FIFODEPTH));
      assert (fifo_count <= credits);
    end
  end

endmodule

// File: tb/tb_blockmem_2p_rd_arb.sv
// Directed bench for blockmem_2p_rd_arb: 3 requesters, latency 2,
// a 16-word memory model returning 0xA5A5_0000 | addr.
module tb_blockmem_2p_rd_arb;

  localparam int NREQ  = 3;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int LAT   = 2;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic [1:0]        rsp_id;
  logic [DW-1:0]     rsp_data;
  logic              rsp_ready = 1'b0;
  logic              mem_enb;
  logic [AW-1:0]     mem_addrb;
  logic [DW-1:0]     mem_doutb;
  logic [DW-1:0]     rd1;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mdata(input logic [AW-1:0] a);
    return 32'hA5A5_0000 | {28'h0, a};
  endfunction

  always @(posedge clk) begin
    if (mem_enb) rd1 <= mdata(mem_addrb);
    mem_doutb <= rd1;
  end

  blockmem_2p_rd_arb #(
    .G_NREQ      (NREQ),
    .G_DATAWIDTH (DW),
    .G_MEMDEPTH  (DEPTH),
    .G_RDLATENCY (LAT)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready),
    .mem_enb   (mem_enb),
    .mem_addrb (mem_addrb),
    .mem_doutb (mem_doutb)
  );

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    req_addr[i*AW +: AW] = a;
  endtask

  task automatic do_reset;
    @(negedge clk);
    resetn = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    resetn = 1'b0;
    req_valid = 3'b111;
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    total++; if (req_ready !== 3'b000) $display("FAIL rst_ready got %b exp 000", req_ready); else passed++;
    total++; if (mem_enb !== 1'b0) $display("FAIL rst_enb got %b exp 0", mem_enb); else passed++;
    total++; if (rsp_valid !== 1'b0) $display("FAIL rst_rspv got %b exp 0", rsp_valid); else passed++;
    total++; if (dut.credits !== 3'd0) $display("FAIL rst_credits got %0d exp 0", dut.credits); else passed++;
    total++; if (dut.last !== 2'd2) $display("FAIL rst_last got %0d exp 2", dut.last); else passed++;
    req_valid = '0;
    resetn = 1'b1;
    #1;
    total++; if (req_ready !== 3'b000) $display("FAIL rst_idle_ready got %b exp 000", req_ready); else passed++;
  endtask

  task automatic test_single_read;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      req_valid = (k == 0) ? 3'b001 : 3'b000;
      set_addr(0, 4'd5);
      rsp_ready = 1'b1;
      #1;
      if (k == 0) begin
        total++; if (req_ready !== 3'b001) $display("FAIL single_ready got %b exp 001", req_ready); else passed++;
        total++; if (mem_enb !== 1'b1 || mem_addrb !== 4'd5) $display("FAIL single_issue got enb=%b addr=%0d exp enb=1 addr=5", mem_enb, mem_addrb); else passed++;
      end else begin
        total++; if (rsp_valid !== (k == 3)) $display("FAIL single_rspv k=%0d got %b exp %b", k, rsp_valid, (k == 3)); else passed++;
        if (k == 3) begin
          total++; if (rsp_id !== 2'd0 || rsp_data !== 32'hA5A5_0005) $display("FAIL single_rsp got id=%0d data=%h exp id=0 data=a5a50005", rsp_id, rsp_data); else passed++;
        end
      end
    end
  endtask

  task automatic test_fairness;
    logic [1:0]    eid;
    logic [AW-1:0] ea;
    logic          ev;
    do_reset();
    for (int i = 0; i < NREQ; i++) set_addr(i, AW'(4 * i + 3));
    rsp_ready = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      req_valid = (k < 9) ? 3'b111 : 3'b000;
      #1;
      if (k < 9) begin
        eid = 2'(k % 3);
        ea = AW'(4 * (k % 3) + 3);
        total++; if (req_ready !== (3'b001 << eid)) $display("FAIL fair_ready k=%0d got %b exp %b", k, req_ready, 3'b001 << eid); else passed++;
        total++; if (mem_enb !== 1'b1 || mem_addrb !== ea) $display("FAIL fair_issue k=%0d got enb=%b addr=%0d exp enb=1 addr=%0d", k, mem_enb, mem_addrb, ea); else passed++;
      end
      ev = (k >= 3 && k < 12);
      total++; if (rsp_valid !== ev) $display("FAIL fair_rspv k=%0d got %b exp %b", k, rsp_valid, ev); else passed++;
      if (ev) begin
        eid = 2'((k - 3) % 3);
        ea = AW'(4 * ((k - 3) % 3) + 3);
        total++; if (rsp_id !== eid || rsp_data !== mdata(ea)) $display("FAIL fair_rsp k=%0d got id=%0d data=%h exp id=%0d data=%h", k, rsp_id, rsp_data, eid, mdata(ea)); else passed++;
      end
    end
  endtask

  task automatic test_backpressure;
    int n;
    int m;
    do_reset();
    n = 0;
    m = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      rsp_ready = 1'b0;
      req_valid = 3'b001;
      set_addr(0, AW'(n));
      #1;
      total++; if (req_ready !== ((k < 4) ? 3'b001 : 3'b000)) $display("FAIL bp_ready k=%0d got %b exp %b", k, req_ready, (k < 4) ? 3'b001 : 3'b000); else passed++;
      if (k == 9) begin
        total++; if (rsp_valid !== 1'b1 || rsp_data !== mdata(4'd0)) $display("FAIL bp_hold got v=%b data=%h exp v=1 data=%h", rsp_valid, rsp_data, mdata(4'd0)); else passed++;
      end
      if (req_ready[0]) n++;
    end
    total++; if (n != 4) $display("FAIL bp_issued got %0d exp 4", n); else passed++;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      rsp_ready = 1'b1;
      req_valid = (n < 10) ? 3'b001 : 3'b000;
      set_addr(0, AW'(n));
      #1;
      if (j == 0) begin
        total++; if (req_ready !== 3'b000) $display("FAIL bp_pop_cycle got %b exp 000", req_ready); else passed++;
      end
      if (j == 1) begin
        total++; if (req_ready !== 3'b001) $display("FAIL bp_reassert got %b exp 001", req_ready); else passed++;
      end
      if (rsp_valid) begin
        total++; if (rsp_id !== 2'd0 || rsp_data !== mdata(AW'(m))) $display("FAIL bp_data m=%0d got id=%0d data=%h exp id=0 data=%h", m, rsp_id, rsp_data, mdata(AW'(m))); else passed++;
        m++;
      end
      if (req_ready[0]) n++;
    end
    total++; if (m != 10 || n != 10) $display("FAIL bp_counts got rsp=%0d iss=%0d exp 10 10", m, n); else passed++;
  endtask

  task automatic test_push_pop;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      req_valid = (k <= 6) ? 3'b001 : 3'b000;
      set_addr(0, (k < 4) ? AW'(k) : 4'd8);
      rsp_ready = (k >= 5);
      #1;
      if (k == 4 || k == 5) begin
        total++; if (req_ready !== 3'b000) $display("FAIL pp_blocked k=%0d got %b exp 000", k, req_ready); else passed++;
      end
      if (k == 5 || k == 6) begin
        total++; if (dut.u_fifo.count !== 3'd3 || dut.u_fifo.full !== 1'b0) $display("FAIL pp_occ k=%0d got cnt=%0d full=%b exp cnt=3 full=0", k, dut.u_fifo.count, dut.u_fifo.full); else passed++;
        total++; if (rsp_data !== mdata(AW'(k - 5))) $display("FAIL pp_head k=%0d got %h exp %h", k, rsp_data, mdata(AW'(k - 5))); else passed++;
      end
      if (k == 6) begin
        total++; if (req_ready !== 3'b001 || mem_addrb !== 4'd8) $display("FAIL pp_issue got rdy=%b addr=%0d exp rdy=001 addr=8", req_ready, mem_addrb); else passed++;
      end
      if (k == 7) begin
        total++; if (dut.u_fifo.count !== 3'd2 || rsp_data !== mdata(4'd2)) $display("FAIL pp_drain got cnt=%0d data=%h exp cnt=2 data=%h", dut.u_fifo.count, rsp_data, mdata(4'd2)); else passed++;
      end
    end
  endtask

  task automatic test_reset_midflight;
    do_reset();
    rsp_ready = 1'b1;
    set_addr(0, 4'd2);
    set_addr(1, 4'd3);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      case (k)
        0: req_valid = 3'b001;
        1: req_valid = 3'b010;
        2: req_valid = 3'b001;
        9: req_valid = 3'b111;
        default: req_valid = 3'b000;
      endcase
      resetn = (k != 2);
      #1;
      if (k == 1) begin
        total++; if (req_ready !== 3'b010) $display("FAIL mid_ready1 got %b exp 010", req_ready); else passed++;
      end
      if (k == 2) begin
        total++; if (req_ready !== 3'b000) $display("FAIL mid_rst_ready got %b exp 000", req_ready); else passed++;
      end
      if (k == 3) begin
        total++; if (dut.credits !== 3'd0) $display("FAIL mid_credits got %0d exp 0", dut.credits); else passed++;
      end
      if (k >= 3 && k <= 8) begin
        total++; if (rsp_valid !== 1'b0) $display("FAIL mid_stale k=%0d got %b exp 0", k, rsp_valid); else passed++;
      end
      if (k == 9) begin
        total++; if (req_ready !== 3'b001) $display("FAIL mid_first_grant got %b exp 001", req_ready); else passed++;
      end
    end
  endtask

  task automatic test_wrap;
    logic [NREQ-1:0] er;
    logic [AW-1:0]   ea;
    logic [1:0]      eid;
    do_reset();
    rsp_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      er = 3'b000;
      ea = '0;
      case (k)
        0: begin req_valid = 3'b010; set_addr(1, 4'd15); er = 3'b010; ea = 4'd15; end
        1: begin req_valid = 3'b101; set_addr(2, 4'd9); set_addr(0, 4'd0); er = 3'b100; ea = 4'd9; end
        2: begin req_valid = 3'b011; set_addr(0, 4'd0); set_addr(1, 4'd6); er = 3'b001; ea = 4'd0; end
        default: req_valid = 3'b000;
      endcase
      #1;
      if (k < 3) begin
        total++; if (req_ready !== er || mem_addrb !== ea) $display("FAIL wrap_issue k=%0d got rdy=%b addr=%0d exp rdy=%b addr=%0d", k, req_ready, mem_addrb, er, ea); else passed++;
      end
      if (k == 3) begin
        total++; if (dut.last !== 2'd0) $display("FAIL wrap_last got %0d exp 0", dut.last); else passed++;
      end
      if (k >= 3 && k <= 5) begin
        eid = (k == 3) ? 2'd1 : (k == 4) ? 2'd2 : 2'd0;
        ea  = (k == 3) ? 4'd15 : (k == 4) ? 4'd9 : 4'd0;
        total++; if (rsp_valid !== 1'b1 || rsp_id !== eid || rsp_data !== mdata(ea)) $display("FAIL wrap_rsp k=%0d got v=%b id=%0d data=%h exp v=1 id=%0d data=%h", k, rsp_valid, rsp_id, rsp_data, eid, mdata(ea)); else passed++;
      end
      if (k == 6) begin
        total++; if (rsp_valid !== 1'b0) $display("FAIL wrap_done got %b exp 0", rsp_valid); else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_fairness();
    test_backpressure();
    test_push_pop();
    test_reset_midflight();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got running exp finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/blockmem_2p_rd_arb.md
# blockmem_2p_rd_arb

Read-port arbiter and response scheduler for `blockmem_2p_wrapper`. It shares the memory's single read port (B) between up to four requesters using round-robin arbitration. It tracks the fixed read latency and buffers returned data in a credit-protected response FIFO, so consumers may stall without losing data. It sits between the AXI read channel logic and port B of the memory; port A (write) is not touched.

## Interface
- G_NREQ, 2, number of read requesters; legal range 2..4
- G_DATAWIDTH, 32, memory data width
- G_MEMDEPTH, 1024, memory depth in words
- G_ADDRWIDTH, $clog2(G_MEMDEPTH), word address width
- G_RDLATENCY, 1, memory read latency in clocks from enb to valid doutb; legal values 1 or 2
- G_FIFODEPTH, G_RDLATENCY+2, response FIFO depth (not user-overridden)

Ports:
- clk  in  1  single clock; the memory's clka and clkb are also tied to it
- resetn  in  1  synchronous, active-low reset
- req_valid  in  G_NREQ  per-requester read request
- req_addr  in  G_NREQ*G_ADDRWIDTH  packed addresses; requester i uses slice [i*G_ADDRWIDTH +: G_ADDRWIDTH]
- req_ready  out  G_NREQ  one-hot-or-zero grant/accept
- rsp_valid  out  1  response available
- rsp_id  out  2  index of the requester that owns rsp_data
- rsp_data  out  G_DATAWIDTH  read data
- rsp_ready  in  1  consumer accepts the response
- mem_enb  out  1  to memory enb
- mem_addrb  out  G_ADDRWIDTH  to memory addrb
- mem_doutb  in  G_DATAWIDTH  from memory doutb

## Operation
- credits = FIFO occupancy + reads in flight; issue is allowed only when credits < G_FIFODEPTH. A pop in the same cycle does not free a credit for that cycle.
- Arbitration is round-robin. The search starts at requester (last+1) mod G_NREQ, where `last` is the last granted requester.
  - `last` updates only on an issue.
  - Reset value of `last` is G_NREQ-1, so requester 0 has first priority.
- req_ready[i] = (i is the first valid requester in RR order) & credit available. At most one bit is set. It is combinational from req_valid, `last` and credits.
- Issue is req_valid[i] & req_ready[i]. On issue, mem_enb=1 and mem_addrb=req_addr[i] in the same cycle. Otherwise mem_enb=0; mem_addrb is don't-care and is driven with requester 0's address.
- An in-flight shift register, G_RDLATENCY stages deep, carries {valid, id}. When a stage exits, mem_doutb is written into the FIFO with that id.
- FIFO head drives rsp_valid, rsp_id and rsp_data. The FIFO pops when rsp_valid & rsp_ready.
- Responses are returned in issue order, across all requesters.
- A FIFO push and pop in the same cycle are both performed; occupancy is unchanged.
- A requester may drop req_valid without a grant; nothing is issued for it.
- The counter bounds credits to 0..G_FIFODEPTH; overflow is impossible by construction. A verification assertion checks that the FIFO is never pushed while full.

## Timing
- Issue at cycle T -> mem_doutb valid at T+G_RDLATENCY -> FIFO push at the end of that cycle -> rsp_valid=1 at the earliest at T+G_RDLATENCY+1.
- With rsp_ready held at 1, throughput is one issue per clock sustained: credits peak at G_RDLATENCY+1 < G_FIFODEPTH.
- With rsp_ready held at 0, at most G_FIFODEPTH reads are issued. req_ready then stays 0 until the first pop, and re-asserts in the cycle after that pop.
- Reset (resetn=0 at a rising edge) values:
  - rsp_valid=0, req_ready=0 (held low while resetn=0), mem_enb=0.
  - FIFO empty, credits=0, in-flight stages cleared, `last`=G_NREQ-1.
- Reset in mid-operation discards all in-flight reads. Data returning from memory after reset is not captured.
- rsp_id, rsp_data and mem_addrb have no defined reset value; they are valid only with their qualifier.

## Structure
- Package blockmem_2p_pkg holds:
  - constant C_MAX_NREQ=4
  - constant C_IDWIDTH=2
  - typedef rd_tag_t = struct {logic valid; logic [C_IDWIDTH-1:0] id;}
- Sub-module blockmem_2p_rsp_fifo: synchronous FIFO, parameterised width/depth, with push/pop/full/empty/count, register storage, sync active-low reset. The arbiter, the in-flight pipe and the credit counter stay in the top module.
- The integration test bench drives port B of blockmem_2p_wrapper from this block.

## Test plan
- Single read: memory preloaded with mem[5]=0xA5A5_0005; req0 at addr 5, rsp_ready=1 -> rsp_valid at T+G_RDLATENCY+1, rsp_id=0, rsp_data=0xA5A5_0005, one cycle only.
- Fairness: G_NREQ=3, all req_valid held high, rsp_ready=1 -> grant sequence 0,1,2,0,1,2…, one issue per clock, responses in the same id order.
- Backpressure: G_RDLATENCY=2, rsp_ready=0, req0 streaming addrs 0..9 -> exactly 4 issues, then req_ready=0. Raise rsp_ready -> data 0..9 delivered in order, none lost or duplicated.
- Simultaneous push and pop: FIFO at depth-1 with one issue in flight and rsp_ready=1 -> occupancy stays constant, no full-flag glitch, issue continues.
- Reset mid-flight: two reads in flight, resetn=0 for 1 cycle -> rsp_valid=0 the next cycle, credits=0, no stale data appears afterwards, and the first post-reset grant goes to req0.
- Wrap-around/boundary: address G_MEMDEPTH-1 from req1, then address 0 from req0 -> correct data for both; `last` wraps from G_NREQ-1 to 0.
